// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - mode codes shared by the LED mode controller
package led_ctrl_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 3'd0,
    MODE_ON    = 3'd1,
    MODE_SLOW  = 3'd2,
    MODE_FAST  = 3'd3,
    MODE_CHASE = 3'd4
  } mode_e;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, level debouncer and rising-edge detect
module btn_debounce #(
  parameter logic [15:0] DEBOUNCE_CYC = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  logic [1:0]  r_sync;
  logic [15:0] r_cnt;
  logic        r_db;
  logic        r_db_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
      r_cnt  <= 16'd0;
      r_db   <= 1'b0;
      r_db_q <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], btn_i};
      r_db_q <= r_db;
      // any sample agreeing with the accepted level restarts the stability window
      if (r_sync[1] == r_db) begin
        r_cnt <= 16'd0;
      end else if (r_cnt == DEBOUNCE_CYC - 16'd1) begin
        r_db  <= r_sync[1];
        r_cnt <= 16'd0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign level_o = r_db;
  assign rise_o  = r_db & ~r_db_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - button-stepped LED mode FSM with prescaled blink and chase patterns
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int          N_LED        = 2,
  parameter logic [15:0] DEBOUNCE_CYC = 16'd50000,
  parameter logic [23:0] BLINK_DIV    = 24'd6000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn1,
  output logic [N_LED-1:0]  led,
  output logic [MODE_W-1:0] mode,
  output logic              press
);

  localparam logic [N_LED-1:0] CHASE_INIT = N_LED'(1);

  logic             w_rise;
  logic             w_unused_level;
  logic             w_tick;
  logic             w_chase_enter;
  logic [N_LED-1:0] w_chase_rot;
  logic [N_LED-1:0] w_led_nxt;
  mode_e            w_mode_nxt;

  mode_e            r_mode;
  logic [23:0]      r_presc;
  logic [1:0]       r_tcnt;
  logic             r_fast;
  logic             r_slow;
  logic [N_LED-1:0] r_chase;
  logic [N_LED-1:0] r_led;
  logic             r_press;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn1),
    .level_o (w_unused_level),
    .rise_o  (w_rise)
  );

  assign w_tick = (r_presc == BLINK_DIV - 24'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= 24'd0;
      r_tcnt  <= 2'd0;
      r_fast  <= 1'b0;
      r_slow  <= 1'b0;
    end else if (w_tick) begin
      r_presc <= 24'd0;
      r_tcnt  <= r_tcnt + 2'd1;
      r_fast  <= ~r_fast;
      if (r_tcnt == 2'd3) begin
        r_slow <= ~r_slow;
      end
    end else begin
      r_presc <= r_presc + 24'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= MODE_OFF;
      r_led   <= '0;
      r_press <= 1'b0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_led   <= w_led_nxt;
      r_press <= w_rise;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    w_led_nxt  = '0;
    case (r_mode)
      MODE_OFF: begin
        if (w_rise) w_mode_nxt = MODE_ON;
      end
      MODE_ON: begin
        w_led_nxt = '1;
        if (w_rise) w_mode_nxt = MODE_SLOW;
      end
      MODE_SLOW: begin
        w_led_nxt = {N_LED{r_slow}};
        if (w_rise) w_mode_nxt = MODE_FAST;
      end
      MODE_FAST: begin
        w_led_nxt = {N_LED{r_fast}};
        if (w_rise) w_mode_nxt = MODE_CHASE;
      end
      MODE_CHASE: begin
        w_led_nxt = r_chase;
        if (w_rise) w_mode_nxt = MODE_OFF;
      end
      default: begin
        w_mode_nxt = MODE_OFF;
      end
    endcase
  end

  generate
    if (N_LED == 1) begin : g_chase_one
      assign w_chase_rot = r_chase;
    end else begin : g_chase_many
      assign w_chase_rot = {r_chase[N_LED-2:0], r_chase[N_LED-1]};
    end
  endgenerate

  // entering CHASE always restarts the pattern, even on a tick cycle
  assign w_chase_enter = (w_mode_nxt == MODE_CHASE) && (r_mode != MODE_CHASE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chase <= CHASE_INIT;
    end else if (w_chase_enter) begin
      r_chase <= CHASE_INIT;
    end else if (w_tick && (r_mode == MODE_CHASE)) begin
      r_chase <= w_chase_rot;
    end
  end

  assign led   = r_led;
  assign mode  = r_mode;
  assign press = r_press;

endmodule
